// File: rtl/cpu_pkg.sv
// Shared types and constants for the 64-bit five-stage core.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        FREEZE
    } hz_state_e;

    localparam logic [4:0]  XZR_IDX   = 5'd31;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter with enable; sticks at all-ones.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch sequencing and hazard control: load-use, taken branch, memory freeze.
// Perf counters are built only when HAZARD_PERF_EN is defined.
module fetch_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int BR_FLUSH_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        id_rn,
    input  logic [4:0]        id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic              br_taken,
    input  logic [63:0]       br_target,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              pc_sel,
    output logic [63:0]       redirect_pc,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              ifid_flush,
    output logic              idex_bubble
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [2:0] FL_RELOAD = 3'(BR_FLUSH_CYCLES - 1);

    hz_state_e   state, stateNext, effState;
    logic [2:0]  flushLeft, flushLeftNext;
    logic        pend, pendNext;
    logic [63:0] pendPc, pendPcNext;
    logic        loadUse, loadUseStall;

    assign loadUse = ex_mem_read && (ex_rd != XZR_IDX) &&
                     ((id_use_rn && (id_rn == ex_rd)) ||
                      (id_use_rm && (id_rm == ex_rd)));

    // Leaving FREEZE behaves in the same cycle as the state it interrupted.
    always_comb begin
        effState = state;
        if (state == FREEZE) begin
            effState = (flushLeft != 3'd0) ? FLUSH : RUN;
        end
    end

    always_comb begin
        pc_en         = 1'b0;
        pc_sel        = 1'b0;
        redirect_pc   = br_target;
        ifid_en       = 1'b0;
        idex_en       = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        loadUseStall  = 1'b0;
        stateNext     = state;
        flushLeftNext = flushLeft;
        pendNext      = pend;
        pendPcNext    = pendPc;
        if (reset) begin
            redirect_pc = 64'd0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            stateNext = FREEZE;
            if (br_taken) begin
                pendNext   = 1'b1;
                pendPcNext = br_target;
            end
        end else if (pend || br_taken) begin
            redirect_pc = pend ? pendPc : br_target;
            pc_sel      = 1'b1;
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            ifid_flush  = 1'b1;
            pendNext    = 1'b0;
            if (BR_FLUSH_CYCLES > 1) begin
                stateNext     = FLUSH;
                flushLeftNext = FL_RELOAD;
            end else begin
                stateNext     = RUN;
                flushLeftNext = 3'd0;
            end
        end else if (effState == FLUSH) begin
            pc_en         = 1'b1;
            ifid_en       = 1'b1;
            idex_en       = 1'b1;
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            flushLeftNext = flushLeft - 3'd1;
            stateNext     = (flushLeft == 3'd1) ? RUN : FLUSH;
        end else if (loadUse) begin
            loadUseStall = 1'b1;
            idex_en      = 1'b1;
            idex_bubble  = 1'b1;
            stateNext    = RUN;
        end else begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            stateNext = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flushLeft <= 3'd0;
            pend      <= 1'b0;
            pendPc    <= 64'd0;
        end else begin
            state     <= stateNext;
            flushLeft <= flushLeftNext;
            pend      <= pendNext;
            pendPc    <= pendPcNext;
        end
    end

`ifdef HAZARD_PERF_EN
    logic stallEn, flushEn;

    assign stallEn = !reset && (mem_busy || loadUseStall);
    assign flushEn = !reset && ifid_flush;

    hazard_perf_cnt #(.CNT_W(CNT_W)) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .en    (stallEn),
        .cnt   (stall_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .en    (flushEn),
        .cnt   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: directed plan steps plus random traffic
// checked against a slot-accounting reference model.
module tb_fetch_hazard_ctrl;

    localparam int BRF = 2;
    localparam int CW  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_mem_read;
    logic [4:0]  ex_rd, id_rn, id_rm;
    logic        id_use_rn, id_use_rm;
    logic        br_taken;
    logic [63:0] br_target;
    logic        mem_busy;
    logic        pc_en, pc_sel, ifid_en, idex_en, ifid_flush, idex_bubble;
    logic [63:0] redirect_pc;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    fetch_hazard_ctrl #(.BR_FLUSH_CYCLES(BRF), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rn       (id_rn),
        .id_rm       (id_rm),
        .id_use_rn   (id_use_rn),
        .id_use_rm   (id_use_rm),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .mem_busy    (mem_busy),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .redirect_pc (redirect_pc),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int nAssert = 0;
    int nFail   = 0;

    // Model: flush slots still owed, a held redirect, event tallies.
    int          owed;
    bit          pendV;
    logic [63:0] pendT;
    int          mStall, mFlush;

    function automatic logic [5:0] ctrl();
        return {pc_en, pc_sel, ifid_en, idex_en, ifid_flush, idex_bubble};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_mem_read = 0; ex_rd = 0; id_rn = 0; id_rm = 0;
        id_use_rn = 0; id_use_rm = 0;
        br_taken = 0; br_target = 64'h0; mem_busy = 0;
    endtask

    task automatic modelReset();
        owed = 0; pendV = 0; pendT = 0; mStall = 0; mFlush = 0;
    endtask

    // Called at posedge+1 with inputs already applied; ends at next posedge+1.
    task automatic step(input string tag);
        logic [5:0]  eCtrl;
        logic [63:0] eRedir;
        bit          lu;
        #3;
`ifdef HAZARD_PERF_EN
        chk({tag, "/stall_cnt"}, 64'(stall_cnt), 64'(mStall));
        chk({tag, "/flush_cnt"}, 64'(flush_cnt), 64'(mFlush));
`endif
        lu = ex_mem_read && ex_rd != 5'd31 &&
             ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
        eRedir = br_target;
        if (mem_busy) begin
            eCtrl = 6'b000000;
            if (br_taken) begin
                pendV = 1;
                pendT = br_target;
            end
            mStall = (mStall == (1 << CW) - 1) ? mStall : mStall + 1;
        end else if (pendV || br_taken) begin
            eCtrl  = 6'b111110;
            eRedir = pendV ? pendT : br_target;
            pendV  = 0;
            owed   = BRF - 1;
            mFlush = (mFlush == (1 << CW) - 1) ? mFlush : mFlush + 1;
        end else if (owed > 0) begin
            eCtrl  = 6'b101111;
            owed   = owed - 1;
            mFlush = (mFlush == (1 << CW) - 1) ? mFlush : mFlush + 1;
        end else if (lu) begin
            eCtrl  = 6'b000101;
            mStall = (mStall == (1 << CW) - 1) ? mStall : mStall + 1;
        end else begin
            eCtrl = 6'b101100;
        end
        chk({tag, "/ctrl"}, 64'(ctrl()), 64'(eCtrl));
        chk({tag, "/redirect"}, redirect_pc, eRedir);
        @(posedge clk);
        #1;
    endtask

    task automatic asyncReset(input string tag);
        #2;
        reset = 1;
        br_target = 64'd99;
        #1;
        chk({tag, "/rst_ctrl"}, 64'(ctrl()), 64'(6'b000011));
        chk({tag, "/rst_redir"}, redirect_pc, 64'd0);
        @(posedge clk);
        #1;
        reset = 0;
        idle();
        modelReset();
    endtask

    initial begin
        bit prevBr;
        idle();
        modelReset();
        reset = 1;
        #2;
        chk("reset/ctrl", 64'(ctrl()), 64'(6'b000011));
        chk("reset/redirect", redirect_pc, 64'd0);
        @(posedge clk);
        #1;
        reset = 0;

        step("run");

        ex_mem_read = 1; ex_rd = 3; id_rn = 3; id_use_rn = 1;
        step("loaduse");
        ex_rd = 31; id_rn = 31;
        step("loaduse_xzr");
        idle();
        ex_mem_read = 1; ex_rd = 7; id_rm = 7; id_use_rm = 1;
        step("loaduse_rm");
        idle();

        br_taken = 1; br_target = 64'd24;
        step("br_redirect");
        idle();
        step("br_flush2");
        step("br_done");

        br_taken = 1; br_target = 64'd48;
        ex_mem_read = 1; ex_rd = 5; id_rn = 5; id_use_rn = 1;
        step("br_over_lu");
        idle();
        step("br_over_lu_flush");

        mem_busy = 1;
        step("freeze1");
        br_taken = 1; br_target = 64'd40;
        step("freeze2");
        br_taken = 0; br_target = 64'd0;
        step("freeze3");
        mem_busy = 0;
        step("replay");
        step("replay_flush");
        step("replay_done");

        br_taken = 1; br_target = 64'd64;
        step("fl_br");
        br_taken = 0;
        mem_busy = 1;
        step("fl_freeze");
        mem_busy = 0;
        step("fl_resume");
        step("fl_done");

        br_taken = 1; br_target = 64'd80;
        step("rst_fl_br");
        idle();
        asyncReset("rst_mid_flush");
        step("after_rst_fl");

        mem_busy = 1; br_taken = 1; br_target = 64'd88;
        step("rst_fz_pend");
        br_taken = 0;
        asyncReset("rst_mid_freeze");
        step("after_rst_fz");

`ifdef HAZARD_PERF_EN
        ex_mem_read = 1; ex_rd = 2; id_rn = 2; id_use_rn = 1;
        for (int i = 0; i < 20; i++) step("sat_lu");
        idle();
        step("sat_idle");
        chk("stall_saturated", 64'(stall_cnt), 64'(4'hF));
`endif

        prevBr = 0;
        for (int i = 0; i < 400; i++) begin
            mem_busy    = ($urandom_range(0, 3) == 0);
            br_taken    = !prevBr && ($urandom_range(0, 5) == 0);
            br_target   = {$urandom, $urandom};
            ex_mem_read = $urandom_range(0, 1);
            ex_rd       = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_rn       = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
            id_rm       = 5'($urandom_range(0, 3));
            id_use_rn   = $urandom_range(0, 1);
            id_use_rm   = $urandom_range(0, 1);
            prevBr      = br_taken;
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Pipeline hazard and fetch sequencing controller for the 64-bit five-stage core. It drives the PC register enable, the branch-redirect select and target into the fetch mux, and the enable and flush controls of the IF/ID and ID/EX registers. It resolves three hazard sources: load-use, taken branch, and data-memory busy. A taken branch that arrives while the pipe is frozen is held and replayed when the freeze ends.

## Interface
Parameters:
- BR_FLUSH_CYCLES, 1: number of consecutive cycles IF/ID is flushed per taken branch (1..4).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- ex_mem_read  in  1  instruction in EX is a load (LDUR).
- ex_rd  in  5  destination register of the EX instruction.
- id_rn, id_rm  in  5 each  source registers of the ID instruction.
- id_use_rn, id_use_rm  in  1 each  ID instruction actually reads that source.
- br_taken  in  1  branch resolved taken this cycle; single-cycle pulse.
- br_target  in  64  branch target; valid while br_taken=1.
- mem_busy  in  1  data memory not ready; the whole pipe must hold.
- pc_en  out  1  PC register enable.
- pc_sel  out  1  1 = PC mux selects redirect_pc.
- redirect_pc  out  64  target fed to the PC mux.
- ifid_en, idex_en  out  1 each  pipeline register enables.
- ifid_flush  out  1  IF/ID loads a NOP (32'h0000_0000) on the next edge.
- idex_bubble  out  1  ID/EX loads all-zero control signals.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters; present only with the macro defined.

## Operation
- States: RUN, FLUSH, FREEZE.
- Hazard priority, highest first: mem_busy, then branch (br_taken or a pending branch), then load-use.
- Load-use condition: ex_mem_read & (ex_rd != 5'd31) & ((id_use_rn & id_rn == ex_rd) | (id_use_rm & id_rm == ex_rd)). XZR (register 31) never stalls.
- RUN, no hazard: pc_en=1, ifid_en=1, idex_en=1; all other controls 0.
- RUN, load-use:
  - pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1.
  - Stays in RUN; the condition clears once the load leaves EX.
- RUN, br_taken:
  - pc_sel=1, redirect_pc=br_target, pc_en=1, ifid_flush=1.
  - Overrides any load-use in the same cycle.
  - If BR_FLUSH_CYCLES>1: go to FLUSH with flush_left=BR_FLUSH_CYCLES-1.
- FLUSH:
  - pc_en=1, ifid_flush=1, idex_bubble=1, pc_sel=0.
  - flush_left decrements each cycle; return to RUN after the cycle in which flush_left==1.
  - A new br_taken in FLUSH redirects again and reloads flush_left=BR_FLUSH_CYCLES-1.
- Any state with mem_busy=1:
  - Go to or stay in FREEZE.
  - pc_en=0, ifid_en=0, idex_en=0, flush/bubble 0.
  - A br_taken seen here sets pend=1 and latches pend_pc=br_target. A later br_taken overwrites pend_pc.
  - On FREEZE entry from FLUSH, flush_left is preserved.
- FREEZE with mem_busy=0:
  - If pend=1: behave as RUN with br_taken using pend_pc, then clear pend.
  - Else: resume the saved state, FLUSH if flush_left>0, otherwise RUN.
- redirect_pc is combinational: pend_pc when replaying, else br_target.

## Timing
- All outputs are combinational from current state and inputs; zero-cycle latency from hazard input to control output.
- Load-use costs exactly 1 bubble.
- A branch costs BR_FLUSH_CYCLES flushed slots.
- A pending branch redirects in the first cycle after mem_busy falls.
- Reset (asynchronous):
  - state=RUN, pend=0, pend_pc=0, flush_left=0, counters=0.
  - While reset=1 the outputs are forced to: pc_en=0, pc_sel=0, redirect_pc=0, ifid_en=0, idex_en=0, ifid_flush=1, idex_bubble=1.
  - Reset mid-FLUSH or mid-FREEZE discards the pending redirect.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments on each load-use cycle and each FREEZE cycle.
  - flush_cnt increments on each cycle with ifid_flush=1 and reset=0.
  - Both saturate at all-ones and reset to 0.
- HAZARD_PERF_EN undefined: both counter ports and their registers are absent.

## Structure
- Shared package cpu_pkg holds:
  - the state typedef hz_state_e {RUN, FLUSH, FREEZE};
  - XZR_IDX=5'd31;
  - NOP_INSTR=32'h0000_0000.
- One sub-module, hazard_perf_cnt: a saturating CNT_W counter with enable, instantiated twice under the macro.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_use_rn=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_bubble=1 that cycle; same stimulus with ex_rd=31 -> no stall.
- Branch, BR_FLUSH_CYCLES=2: br_taken pulse, br_target=64'd24 -> pc_sel=1, redirect_pc=24, ifid_flush=1 for 2 consecutive cycles, then RUN.
- Branch and load-use in the same cycle -> branch redirect, pc_en=1, no load-use stall.
- mem_busy high for 3 cycles with br_taken (target 64'd40) in the 2nd cycle -> all enables 0 for 3 cycles; cycle 4 shows pc_sel=1, redirect_pc=40.
- reset asserted mid-FLUSH, asynchronously between edges -> outputs immediately take reset values; after release, RUN with no flush.
- With HAZARD_PERF_EN, CNT_W=4: 20 load-use cycles -> stall_cnt saturates at 4'hF.
